// File: rtl/pll_lock_sequencer.sv
// PLLVR reset/divider sequencer with lock qualification,
// timeout retry and runtime divider reprogramming.
module pll_lock_sequencer #(
    parameter int         RST_CYCLES    = 16,
    parameter int         STABLE_CYCLES = 1024,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         MAX_RETRY     = 3,
    parameter logic [5:0] IDSEL_INIT    = 6'd0,
    parameter logic [5:0] FBDSEL_INIT   = 6'd0,
    parameter logic [5:0] ODSEL_INIT    = 6'd0
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       cfg_req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       pll_reset,
    output logic [5:0] idsel,
    output logic [5:0] fbdsel,
    output logic [5:0] odsel,
    output logic       locked,
    output logic       sys_rst,
    output logic       busy,
    output logic       err,
    output logic [7:0] loss_cnt
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int ST_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int RT_W = $clog2(MAX_RETRY + 1);

    localparam logic [2:0] S_RST_PLL = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_STABLE  = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;

    logic [2:0]      state, state_d;
    logic [RC_W-1:0] rst_cnt, rst_cnt_d;
    logic [ST_W-1:0] st_cnt, st_cnt_d;
    logic [TO_W-1:0] to_cnt, to_cnt_d;
    logic [RT_W-1:0] retry, retry_d, retry_inc;
    logic [7:0]      loss_d;
    logic [5:0]      id_d, fb_d, od_d;
    logic            lock_m, lock_s;
    logic            timeout, stable_done;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    assign timeout   = (to_cnt == TO_W'(LOCK_TIMEOUT - 1));
    assign retry_inc = retry + RT_W'(1);
    // the WAIT_LOCK cycle that saw lock_s is the first stable cycle
    assign stable_done = lock_s &&
        (int'(st_cnt) + 2 >= STABLE_CYCLES);

    always_comb begin
        state_d   = state;
        rst_cnt_d = rst_cnt;
        st_cnt_d  = st_cnt;
        to_cnt_d  = to_cnt;
        retry_d   = retry;
        loss_d    = loss_cnt;
        id_d      = idsel;
        fb_d      = fbdsel;
        od_d      = odsel;
        unique case (1'b1)
            (state == S_RST_PLL): begin
                if (rst_cnt == RC_W'(RST_CYCLES - 1))
                    state_d = S_WAIT;
                else
                    rst_cnt_d = rst_cnt + RC_W'(1);
            end
            (state == S_WAIT): begin
                if (timeout) begin
                    retry_d = retry_inc;
                    state_d = (int'(retry_inc) == MAX_RETRY)
                            ? S_FAIL : S_RST_PLL;
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                    if (lock_s)
                        state_d = S_STABLE;
                end
            end
            (state == S_STABLE): begin
                if (stable_done) begin
                    state_d = S_RUN;
                end else if (timeout) begin
                    retry_d = retry_inc;
                    state_d = (int'(retry_inc) == MAX_RETRY)
                            ? S_FAIL : S_RST_PLL;
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                    if (lock_s)
                        st_cnt_d = st_cnt + ST_W'(1);
                    else
                        state_d = S_WAIT;
                end
            end
            (state == S_RUN || state == S_FAIL): begin
                if (cfg_req) begin
                    id_d    = cfg_idsel;
                    fb_d    = cfg_fbdsel;
                    od_d    = cfg_odsel;
                    retry_d = '0;
                    state_d = S_RST_PLL;
                end else if (state == S_RUN && !lock_s) begin
                    if (loss_cnt != 8'hff)
                        loss_d = loss_cnt + 8'd1;
                    state_d = S_RST_PLL;
                end
            end
            default: state_d = S_RST_PLL;
        endcase
        // per-state counters restart on entry
        if (state_d != state) begin
            if (state_d == S_RST_PLL) rst_cnt_d = '0;
            if (state_d == S_STABLE)  st_cnt_d  = '0;
            if (state_d == S_WAIT &&
                state == S_RST_PLL)   to_cnt_d  = '0;
            if (state_d == S_RUN)     retry_d   = '0;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state    <= S_RST_PLL;
            rst_cnt  <= '0;
            st_cnt   <= '0;
            to_cnt   <= '0;
            retry    <= '0;
            loss_cnt <= 8'd0;
            idsel    <= IDSEL_INIT;
            fbdsel   <= FBDSEL_INIT;
            odsel    <= ODSEL_INIT;
            locked   <= 1'b0;
            sys_rst  <= 1'b1;
        end else begin
            state    <= state_d;
            rst_cnt  <= rst_cnt_d;
            st_cnt   <= st_cnt_d;
            to_cnt   <= to_cnt_d;
            retry    <= retry_d;
            loss_cnt <= loss_d;
            idsel    <= id_d;
            fbdsel   <= fb_d;
            odsel    <= od_d;
            locked   <= (state_d == S_RUN);
            sys_rst  <= (state_d != S_RUN);
        end
    end

    assign pll_reset = (state == S_RST_PLL);
    assign busy      = (state == S_RST_PLL) ||
                       (state == S_WAIT) ||
                       (state == S_STABLE);
    assign err       = (state == S_FAIL);

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus
// random lock/cfg/rst traffic against a phase-level model.
module tb_pll_lock_sequencer;

    localparam int RST = 4;
    localparam int STB = 8;
    localparam int TO  = 100;
    localparam int MR  = 3;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       cfg_req = 1'b0;
    logic [5:0] cfg_idsel = '0;
    logic [5:0] cfg_fbdsel = '0;
    logic [5:0] cfg_odsel = '0;
    logic       pll_reset, locked, sys_rst, busy, err;
    logic [5:0] idsel, fbdsel, odsel;
    logic [7:0] loss_cnt;

    pll_lock_sequencer #(
        .RST_CYCLES(RST), .STABLE_CYCLES(STB),
        .LOCK_TIMEOUT(TO), .MAX_RETRY(MR),
        .IDSEL_INIT(6'd0), .FBDSEL_INIT(6'd0),
        .ODSEL_INIT(6'd0)
    ) dut (
        .clkin(clkin), .rst(rst), .pll_lock(pll_lock),
        .cfg_req(cfg_req), .cfg_idsel(cfg_idsel),
        .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
        .pll_reset(pll_reset), .idsel(idsel),
        .fbdsel(fbdsel), .odsel(odsel), .locked(locked),
        .sys_rst(sys_rst), .busy(busy), .err(err),
        .loss_cnt(loss_cnt)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d",
                     name, act, exp);
        end
    endtask

    // phases: 0 pulse, 1 waiting (lock+stable), 2 run, 3 fail
    int         m_ph = 0, m_rc = 0, m_el = 0, m_run = 0;
    int         m_retry = 0, m_loss = 0;
    logic       m_s1 = 0, m_s2 = 0;
    logic [5:0] m_id = 0, m_fb = 0, m_od = 0;

    task automatic model_reset();
        m_ph = 0; m_rc = 0; m_el = 0; m_run = 0;
        m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
        m_id = 0; m_fb = 0; m_od = 0;
    endtask

    task automatic model_step();
        logic ls;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_lock;
        case (m_ph)
            0: begin
                m_rc++;
                if (m_rc == RST) begin
                    m_ph = 1; m_el = 0; m_run = 0;
                end
            end
            1: begin
                m_run = ls ? m_run + 1 : 0;
                if (m_run >= STB) begin
                    m_ph = 2; m_retry = 0;
                end else if (m_el + 1 == TO) begin
                    m_retry++;
                    if (m_retry == MR) m_ph = 3;
                    else begin m_ph = 0; m_rc = 0; end
                end else m_el++;
            end
            default: begin
                if (cfg_req) begin
                    m_id = cfg_idsel; m_fb = cfg_fbdsel;
                    m_od = cfg_odsel; m_retry = 0;
                    m_ph = 0; m_rc = 0;
                end else if (m_ph == 2 && !ls) begin
                    if (m_loss < 255) m_loss++;
                    m_ph = 0; m_rc = 0;
                end
            end
        endcase
    endtask

    always begin
        @(posedge clkin);
        if (rst) model_reset();
        else model_step();
        #1;
        chk("pll_reset", 32'(pll_reset), 32'(m_ph == 0));
        chk("busy", 32'(busy), 32'(m_ph <= 1));
        chk("err", 32'(err), 32'(m_ph == 3));
        chk("locked", 32'(locked), 32'(m_ph == 2));
        chk("sys_rst", 32'(sys_rst), 32'(m_ph != 2));
        chk("idsel", 32'(idsel), 32'(m_id));
        chk("fbdsel", 32'(fbdsel), 32'(m_fb));
        chk("odsel", 32'(odsel), 32'(m_od));
        chk("loss_cnt", 32'(loss_cnt), m_loss);
    end

    task automatic tick();
        @(posedge clkin);
        #2;
    endtask

    task automatic wait_locked(input string name);
        int k;
        k = 0;
        while (!locked && k < 400) begin
            tick(); k++;
        end
        chk(name, 32'(locked), 1);
    endtask

    task automatic set_cfg(input logic [5:0] a,
                           input logic [5:0] b,
                           input logic [5:0] c);
        cfg_idsel = a; cfg_fbdsel = b; cfg_odsel = c;
    endtask

    int n, pulses, waits, seen, hold;
    logic prev;

    initial begin
        repeat (3) tick();
        chk("rst_pll_reset", 32'(pll_reset), 1);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_sys_rst", 32'(sys_rst), 1);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_err", 32'(err), 0);
        chk("rst_loss", 32'(loss_cnt), 0);
        rst = 0;

        n = 0;
        while (pll_reset && n < 50) begin tick(); n++; end
        chk("t1_pulse_len", n, 4);
        repeat (10) tick();
        pll_lock = 1;
        n = 0;
        while (!locked && n < 200) begin tick(); n++; end
        chk("t1_lock_latency", n, 10);
        chk("t1_sys_rst", 32'(sys_rst), 0);

        repeat (5) tick();
        pll_lock = 0;
        tick();
        pll_lock = 1;
        n = 1;
        while (locked && n < 20) begin tick(); n++; end
        chk("t2_fall_latency", n, 3);
        chk("t2_loss", 32'(loss_cnt), 1);
        n = 0;
        while (pll_reset && n < 50) begin tick(); n++; end
        chk("t2_pulse_len", n, 4);
        wait_locked("t2_relock");

        pll_lock = 0;
        pulses = 0; waits = 0; n = 0;
        prev = pll_reset;
        while (!err && n < 1000) begin
            tick(); n++;
            if (pll_reset && !prev) pulses++;
            prev = pll_reset;
            if (busy && !pll_reset) waits++;
        end
        chk("t3_pulses", pulses, 3);
        chk("t3_wait_cycles", waits, 300);
        chk("t3_err", 32'(err), 1);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_pll_reset", 32'(pll_reset), 0);

        set_cfg(6'd5, 6'd9, 6'd56);
        cfg_req = 1; pll_lock = 1;
        tick();
        cfg_req = 0;
        chk("t4_idsel", 32'(idsel), 5);
        chk("t4_fbdsel", 32'(fbdsel), 9);
        chk("t4_odsel", 32'(odsel), 56);
        chk("t4_err", 32'(err), 0);
        chk("t4_pll_reset", 32'(pll_reset), 1);
        wait_locked("t4_lock");

        cfg_req = 1; pll_lock = 0;
        tick();
        cfg_req = 0;
        n = 0;
        while (pll_reset && n < 50) begin tick(); n++; end
        pll_lock = 1;
        n = 0; seen = 0;
        while (!pll_reset && n < 300) begin
            if (n > 0 && n % 5 == 0) pll_lock = ~pll_lock;
            tick(); n++;
            if (locked) seen++;
        end
        chk("t5_timeout_len", n, 100);
        chk("t5_never_locked", seen, 0);
        pll_lock = 1;
        wait_locked("t5_retry_lock");

        pll_lock = 0;
        n = 0;
        while (locked && n < 20) begin tick(); n++; end
        set_cfg(6'd1, 6'd2, 6'd3);
        cfg_req = 1;
        tick();
        cfg_req = 0;
        chk("t6_busy_idsel", 32'(idsel), 5);
        chk("t6_busy_fbdsel", 32'(fbdsel), 9);
        chk("t6_busy_odsel", 32'(odsel), 56);
        pll_lock = 1;
        wait_locked("t6_relock");
        chk("t6_loss_before", 32'(loss_cnt), 3);
        pll_lock = 0;
        tick();
        tick();
        set_cfg(6'd7, 6'd11, 6'd13);
        cfg_req = 1;
        tick();
        cfg_req = 0; pll_lock = 1;
        chk("t6_same_idsel", 32'(idsel), 7);
        chk("t6_same_odsel", 32'(odsel), 13);
        chk("t6_same_loss", 32'(loss_cnt), 3);
        chk("t6_same_reset", 32'(pll_reset), 1);
        wait_locked("t6_same_lock");

        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    pll_lock = 0;
                    hold = ($urandom_range(0, 9) == 0)
                         ? int'($urandom_range(300, 450))
                         : int'($urandom_range(1, 12));
                end else begin
                    pll_lock = 1;
                    hold = int'($urandom_range(5, 60));
                end
            end else hold--;
            cfg_req = ($urandom_range(0, 49) == 0);
            if (cfg_req)
                set_cfg(6'($urandom_range(0, 63)),
                        6'($urandom_range(0, 63)),
                        6'($urandom_range(0, 63)));
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 0; cfg_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
